fsm_vector_sequencer: RTL and testbench

- Sequences a small 3-input/4-output registered FSM core, such as the c-series benchmark controllers, through a programmed list of input vectors.
- Holds up to DEPTH vector/expected-response pairs and resets the core before each run.
- Applies one vector per cycle, compares the core's registered outputs against the expected values, and reports a saturating mismatch count plus the first failing index.
- Sits between the test/config host and one core instance.

---
 rtl/fsm_vector_sequencer_if.sv | 34 +++
 rtl/fsm_vector_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_fsm_vector_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fsm_vector_sequencer_if.sv
// Host/core bundle for the vector sequencer: config writes, run control,
// results, and the drive/observe pins toward the core under test.
interface fsm_vector_sequencer_if #(
    parameter int AW    = 4,
    parameter int IN_W  = 3,
    parameter int OUT_W = 4,
    parameter int CNT_W = 8
);
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [IN_W+OUT_W-1:0] wr_data;
    logic                  start;
    logic [AW:0]           num_vec;
    logic                  busy;
    logic                  done;
    logic [CNT_W-1:0]      err_cnt;
    logic [AW-1:0]         first_fail;
    logic                  fail_seen;
    logic                  core_rst;
    logic [IN_W-1:0]       core_in;
    logic [OUT_W-1:0]      core_out;

    // Environment side: host plus the core instance.
    modport master (
        output wr_en, wr_addr, wr_data, start, num_vec, core_out,
        input  busy, done, err_cnt, first_fail, fail_seen, core_rst, core_in
    );

    // Sequencer side.
    modport slave (
        input  wr_en, wr_addr, wr_data, start, num_vec, core_out,
        output busy, done, err_cnt, first_fail, fail_seen, core_rst, core_in
    );
endinterface

// File: rtl/fsm_vector_sequencer.sv
// Vector sequencer: resets a small registered core, replays a stored list of
// input vectors one per cycle and scores the core outputs against the stored
// expected responses, LAT cycles later.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; vector memory writable; results held
// CRST   | core_rst high for RST_CYC cycles, core_in = 0
// RUN    | vector[k] on core_in, k = 0..len-1, entry pushed to pipeline
// DRAIN  | LAT cycles of idle input so the last responses get compared
// FIN    | one-cycle done pulse, busy already low
module fsm_vector_sequencer #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int IN_W    = 3,
    parameter int OUT_W   = 4,
    parameter int LAT     = 1,
    parameter int RST_CYC = 2,
    parameter int CNT_W   = 8
) (
    input logic                  clk,
    input logic                  rst,
    fsm_vector_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CRST,
        S_RUN,
        S_DRAIN,
        S_FIN
    } state_t;

    localparam logic [AW:0] DEPTH_L  = (AW + 1)'(DEPTH);
    localparam logic [3:0]  TMR_RST  = 4'(RST_CYC - 1);
    localparam logic [3:0]  TMR_LAT  = 4'(LAT - 1);

    state_t state_q, state_d;
    logic [AW:0]      len_q, len_d;
    logic [AW:0]      idx_q, idx_d;
    logic [3:0]       tmr_q, tmr_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [AW-1:0]    ff_q, ff_d;
    logic             fs_q, fs_d;

    logic [LAT-1:0]            pv_q, pv_d;
    logic [LAT-1:0][AW-1:0]    pidx_q, pidx_d;
    logic [LAT-1:0][OUT_W-1:0] pexp_q, pexp_d;

    logic [IN_W+OUT_W-1:0] mem_q [DEPTH];
    logic [IN_W+OUT_W-1:0] rd_word;
    logic                  mem_we;

    assign rd_word = mem_q[idx_q[AW-1:0]];
    assign mem_we  = (state_q == S_IDLE) && bus.wr_en;

    // Vector memory: written only while idle, contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Next state, counters, compare pipeline and outputs.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        err_d   = err_q;
        ff_d    = ff_q;
        fs_d    = fs_q;
        pv_d    = '0;
        pidx_d  = pidx_q;
        pexp_d  = pexp_q;

        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.core_rst = 1'b0;
        bus.core_in  = '0;

        // Pipeline shifts every cycle; only RUN pushes a valid entry and
        // outside RUN/DRAIN everything stays invalid.
        for (int i = LAT - 1; i > 0; i--) begin
            pv_d[i]   = pv_q[i-1];
            pidx_d[i] = pidx_q[i-1];
            pexp_d[i] = pexp_q[i-1];
        end
        pv_d[0]   = 1'b0;
        pidx_d[0] = idx_q[AW-1:0];
        pexp_d[0] = rd_word[IN_W+OUT_W-1:IN_W];

        // Score the pipeline head against the core's registered outputs.
        if ((state_q == S_RUN || state_q == S_DRAIN) && pv_q[LAT-1] &&
            (bus.core_out != pexp_q[LAT-1])) begin
            if (err_q != {CNT_W{1'b1}}) begin
                err_d = err_q + CNT_W'(1);
            end
            if (!fs_q) begin
                ff_d = pidx_q[LAT-1];
                fs_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    len_d   = (bus.num_vec > DEPTH_L) ? DEPTH_L : bus.num_vec;
                    err_d   = '0;
                    ff_d    = '0;
                    fs_d    = 1'b0;
                    tmr_d   = TMR_RST;
                    state_d = S_CRST;
                end
            end
            S_CRST: begin
                bus.busy     = 1'b1;
                bus.core_rst = 1'b1;
                if (tmr_q == 4'd0) begin
                    idx_d   = '0;
                    state_d = (len_q != '0) ? S_RUN : S_FIN;
                end else begin
                    tmr_d = tmr_q - 4'd1;
                end
            end
            S_RUN: begin
                bus.busy    = 1'b1;
                bus.core_in = rd_word[IN_W-1:0];
                pv_d[0]     = 1'b1;
                if (idx_q == len_q - 1'b1) begin
                    tmr_d   = TMR_LAT;
                    state_d = S_DRAIN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DRAIN: begin
                bus.busy = 1'b1;
                if (tmr_q == 4'd0) begin
                    state_d = S_FIN;
                end else begin
                    tmr_d = tmr_q - 4'd1;
                end
            end
            S_FIN: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (!(state_q == S_RUN || state_q == S_DRAIN)) begin
            pv_d = '0;
        end
    end

    assign bus.err_cnt    = err_q;
    assign bus.first_fail = ff_q;
    assign bus.fail_seen  = fs_q;

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            tmr_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            fs_q    <= 1'b0;
            pv_q    <= '0;
            pidx_q  <= '0;
            pexp_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            fs_q    <= fs_d;
            pv_q    <= pv_d;
            pidx_q  <= pidx_d;
            pexp_q  <= pexp_d;
        end
    end

endmodule

// File: tb/tb_fsm_vector_sequencer.sv
// Directed bench for fsm_vector_sequencer: a toy registered core
// (out = {in[2]^in[1], in}) is scored against hand-computed vector tables.
module tb_fsm_vector_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fsm_vector_sequencer_if #(.AW(4), .IN_W(3), .OUT_W(4), .CNT_W(8)) if1 ();
    fsm_vector_sequencer_if #(.AW(4), .IN_W(3), .OUT_W(4), .CNT_W(2)) if2 ();

    fsm_vector_sequencer #(
        .DEPTH(16), .AW(4), .IN_W(3), .OUT_W(4), .LAT(1), .RST_CYC(2), .CNT_W(8)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    fsm_vector_sequencer #(
        .DEPTH(16), .AW(4), .IN_W(3), .OUT_W(4), .LAT(1), .RST_CYC(2), .CNT_W(2)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2.slave)
    );

    logic [3:0] core1_q = 4'h0;
    logic [3:0] core2_q = 4'h0;
    assign if1.core_out = core1_q;
    assign if2.core_out = core2_q;

    // Toy cores, one register stage between core_in and core_out.
    always @(posedge clk) begin
        core1_q <= if1.core_rst ? 4'h0 : {if1.core_in[2] ^ if1.core_in[1], if1.core_in};
        core2_q <= if2.core_rst ? 4'h0 : {if2.core_in[2] ^ if2.core_in[1], if2.core_in};
    end

    localparam logic [2:0] VEC [4] = '{3'b001, 3'b110, 3'b101, 3'b011};
    localparam logic [3:0] EXP [4] = '{4'h1, 4'h6, 4'hD, 4'hB};

    int n_checks = 0;
    int n_errors = 0;

    logic [2:0] tr_in  [64];
    logic       tr_rst [64];
    int         done_cyc;
    int         busy_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] core_f(input logic [2:0] v);
        return {v[2] ^ v[1], v};
    endfunction

    task automatic wr1(input logic [3:0] a, input logic [6:0] d);
        if1.wr_en   = 1'b1;
        if1.wr_addr = a;
        if1.wr_data = d;
        @(posedge clk); #1;
        if1.wr_en   = 1'b0;
    endtask

    task automatic load_base();
        for (int i = 0; i < 4; i++) wr1(4'(i), {EXP[i], VEC[i]});
    endtask

    // Start a run on dut1 and trace core_in/core_rst per cycle. Cycle 1 is
    // the one right after the edge that accepted start.
    task automatic run1(input logic [4:0] n, input bit disturb);
        for (int i = 0; i < 64; i++) begin
            tr_in[i]  = 3'b000;
            tr_rst[i] = 1'b0;
        end
        busy_cnt      = 0;
        if1.start     = 1'b1;
        if1.num_vec   = n;
        @(posedge clk); #1;
        if1.start     = 1'b0;
        done_cyc      = 1;
        tr_in[1]      = if1.core_in;
        tr_rst[1]     = if1.core_rst;
        if (if1.busy) busy_cnt++;
        while (!if1.done && done_cyc < 60) begin
            if (disturb && done_cyc == 4) begin
                if1.start   = 1'b1;
                if1.num_vec = 5'd1;
                if1.wr_en   = 1'b1;
                if1.wr_addr = 4'd0;
                if1.wr_data = 7'h7F;
            end
            @(posedge clk); #1;
            if1.start = 1'b0;
            if1.wr_en = 1'b0;
            done_cyc++;
            tr_in[done_cyc]  = if1.core_in;
            tr_rst[done_cyc] = if1.core_rst;
            if (if1.busy) busy_cnt++;
        end
        check("done_seen", {31'd0, if1.done}, 32'd1);
        check("busy_at_done", {31'd0, if1.busy}, 32'd0);
        @(posedge clk); #1;
        check("done_one_cycle", {31'd0, if1.done}, 32'd0);
    endtask

    initial begin
        int dones;
        int cyc;
        if1.wr_en = 0; if1.wr_addr = '0; if1.wr_data = '0; if1.start = 0; if1.num_vec = '0;
        if2.wr_en = 0; if2.wr_addr = '0; if2.wr_data = '0; if2.start = 0; if2.num_vec = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, if1.busy}, 32'd0);
        check("rst_done", {31'd0, if1.done}, 32'd0);
        check("rst_err", {24'd0, if1.err_cnt}, 32'd0);
        check("rst_ff", {28'd0, if1.first_fail}, 32'd0);
        check("rst_fs", {31'd0, if1.fail_seen}, 32'd0);
        check("rst_core_rst", {31'd0, if1.core_rst}, 32'd0);
        check("rst_core_in", {29'd0, if1.core_in}, 32'd0);
        rst = 1'b0;

        // Clean 4-vector run.
        load_base();
        run1(5'd4, 1'b0);
        check("s1_latency", done_cyc, 8);
        check("s1_busy_cycles", busy_cnt, 7);
        check("s1_crst_c1", {31'd0, tr_rst[1]}, 32'd1);
        check("s1_crst_c2", {31'd0, tr_rst[2]}, 32'd1);
        check("s1_crst_c3", {31'd0, tr_rst[3]}, 32'd0);
        check("s1_in_during_crst", {29'd0, tr_in[2]}, 32'd0);
        for (int i = 0; i < 4; i++) check($sformatf("s1_core_in_%0d", i), {29'd0, tr_in[3+i]}, {29'd0, VEC[i]});
        check("s1_in_drain", {29'd0, tr_in[7]}, 32'd0);
        check("s1_err", {24'd0, if1.err_cnt}, 32'd0);
        check("s1_fs", {31'd0, if1.fail_seen}, 32'd0);

        // Slot 2 expected corrupted.
        wr1(4'd2, {EXP[2] ^ 4'h8, VEC[2]});
        run1(5'd4, 1'b0);
        check("s2_err", {24'd0, if1.err_cnt}, 32'd1);
        check("s2_ff", {28'd0, if1.first_fail}, 32'd2);
        check("s2_fs", {31'd0, if1.fail_seen}, 32'd1);

        // Slots 1 and 3 corrupted.
        wr1(4'd2, {EXP[2], VEC[2]});
        wr1(4'd1, {EXP[1] ^ 4'h1, VEC[1]});
        wr1(4'd3, {EXP[3] ^ 4'h4, VEC[3]});
        run1(5'd4, 1'b0);
        check("s3_err", {24'd0, if1.err_cnt}, 32'd2);
        check("s3_ff", {28'd0, if1.first_fail}, 32'd1);

        // Zero-length run.
        run1(5'd0, 1'b0);
        check("s4_latency", done_cyc, 3);
        check("s4_crst_c2", {31'd0, tr_rst[2]}, 32'd1);
        check("s4_no_vec", {29'd0, tr_in[1] | tr_in[2] | tr_in[3]}, 32'd0);
        check("s4_err", {24'd0, if1.err_cnt}, 32'd0);
        check("s4_fs", {31'd0, if1.fail_seen}, 32'd0);

        // start/wr_en during RUN must be ignored.
        load_base();
        run1(5'd4, 1'b1);
        check("s5_latency", done_cyc, 8);
        check("s5_busy_cycles", busy_cnt, 7);
        check("s5_err", {24'd0, if1.err_cnt}, 32'd0);
        @(posedge clk); #1;
        check("s5_no_restart", {31'd0, if1.busy}, 32'd0);
        run1(5'd4, 1'b0);
        check("s5_slot0_kept", {29'd0, tr_in[3]}, {29'd0, VEC[0]});
        check("s5_rerun_err", {24'd0, if1.err_cnt}, 32'd0);

        // Reset mid-RUN at k=2.
        if1.start = 1'b1; if1.num_vec = 5'd4;
        @(posedge clk); #1;
        if1.start = 1'b0;
        cyc = 1;
        while (cyc < 5) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("s6_in_k2", {29'd0, if1.core_in}, {29'd0, VEC[2]});
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("s6_busy", {31'd0, if1.busy}, 32'd0);
        check("s6_core_in", {29'd0, if1.core_in}, 32'd0);
        check("s6_core_rst", {31'd0, if1.core_rst}, 32'd0);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            if (if1.done || if1.busy) dones++;
            @(posedge clk); #1;
        end
        check("s6_no_done", dones, 0);
        run1(5'd4, 1'b0);
        check("s6_new_latency", done_cyc, 8);
        check("s6_new_err", {24'd0, if1.err_cnt}, 32'd0);

        // num_vec=17 clamps to 16; slot 15 deliberately wrong.
        for (int i = 0; i < 16; i++) begin
            logic [2:0] v;
            v = 3'(i);
            wr1(4'(i), {(i == 15) ? ~core_f(v) : core_f(v), v});
        end
        run1(5'd17, 1'b0);
        check("s7_latency", done_cyc, 20);
        check("s7_in_k15", {29'd0, tr_in[18]}, 32'd7);
        check("s7_in_k14", {29'd0, tr_in[17]}, 32'd6);
        check("s7_in_drain", {29'd0, tr_in[19]}, 32'd0);
        check("s7_err", {24'd0, if1.err_cnt}, 32'd1);
        check("s7_ff", {28'd0, if1.first_fail}, 32'd15);

        // CNT_W=2 saturation on dut2.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            if2.wr_en = 1'b1; if2.wr_addr = 4'(i); if2.wr_data = {~core_f(v), v};
            @(posedge clk); #1;
        end
        if2.wr_en = 1'b0;
        if2.start = 1'b1; if2.num_vec = 5'd8;
        @(posedge clk); #1;
        if2.start = 1'b0;
        cyc = 1;
        while (!if2.done && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("s8_done_seen", {31'd0, if2.done}, 32'd1);
        check("s8_latency", cyc, 12);
        check("s8_err_sat", {30'd0, if2.err_cnt}, 32'd3);
        check("s8_ff", {28'd0, if2.first_fail}, 32'd0);
        check("s8_fs", {31'd0, if2.fail_seen}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
